// File: rtl/hd44780_pkg.sv
// Shared constants, opcode classes and DDRAM address helpers for the HD44780 panel responder.
package hd44780_pkg;

    localparam logic [6:0] DDRAM_LINE0 = 7'h00;
    localparam logic [6:0] DDRAM_LINE1 = 7'h40;
    localparam int         LINE_LEN    = 40;
    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [6:0] LINE0_LAST  = DDRAM_LINE0 + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE1_LAST  = DDRAM_LINE1 + 7'(LINE_LEN - 1);

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISPLAY,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } op_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

    // Highest set bit selects the instruction class.
    function automatic op_t decode_op(input logic [7:0] d);
        if (d[7]) return OP_DDRAM;
        if (d[6]) return OP_CGRAM;
        if (d[5]) return OP_FUNC;
        if (d[4]) return OP_SHIFT;
        if (d[3]) return OP_DISPLAY;
        if (d[2]) return OP_ENTRY;
        if (d[1]) return OP_HOME;
        if (d[0]) return OP_CLEAR;
        return OP_NOP;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LINE0_LAST) return DDRAM_LINE1;
            if (ac == LINE1_LAST) return DDRAM_LINE0;
            return ac + 7'd1;
        end
        if (ac == DDRAM_LINE0) return LINE1_LAST;
        if (ac == DDRAM_LINE1) return LINE0_LAST;
        return ac - 7'd1;
    endfunction

    function automatic logic ddram_legal(input logic [6:0] a);
        return (a <= LINE0_LAST) || ((a >= DDRAM_LINE1) && (a <= LINE1_LAST));
    endfunction

    // Line 1 follows line 0 in the linear RAM.
    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'(LINE_LEN)) : {1'b0, a[5:0]};
    endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 80x8 display data RAM: one write port, synchronous read ports for the LCD bus and the scan-out.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] bus_addr,
    output logic [7:0] bus_q,
    input  logic [6:0] scan_addr,
    output logic [7:0] scan_q
);

    logic [7:0] mem [0:2*LINE_LEN-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[ddram_index(waddr)] <= wdata;
        end
        bus_q  <= mem[ddram_index(bus_addr)];
        scan_q <= mem[ddram_index(scan_addr)];
    end

endmodule

// File: rtl/hd44780_panel_responder.sv
// Device side of an 8-bit HD44780 LCD bus with a scan port for text overlay rendering.
// Optional CGRAM and glyph read port are enabled by defining HD44780_CGRAM_EN.
module hd44780_panel_responder
    import hd44780_pkg::*;
#(
    parameter int BUSY_CYCLES  = 50,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] LCD_DATA,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_ON,
    input  logic       scan_row,
    input  logic [3:0] scan_col,
    output logic [7:0] scan_char,
    output logic       scan_cursor,
    output logic       disp_on,
    output logic       busy,
    output logic       cmd_err
`ifdef HD44780_CGRAM_EN
    ,
    input  logic [5:0] cg_addr,
    output logic [4:0] cg_data
`endif
);

    localparam int         CNT_W    = $clog2(CLEAR_CYCLES + 1);
    localparam logic [6:0] CLR_LAST = 7'(2 * LINE_LEN - 1);

    logic             en_q;
    logic             rise;
    logic             fall;
    logic             wr_strobe;
    logic [7:0]       rd_q;
    logic [7:0]       rd_snap;
    logic [7:0]       bus_rdata;
    logic [7:0]       ram_bus_q;
    logic [7:0]       ram_scan_q;
    logic [7:0]       ram_wdata;
    logic [6:0]       ram_waddr;
    logic             ram_we;
    logic [6:0]       ac;
    logic [6:0]       ac_d;
    logic [6:0]       ac_adv;
    logic             id;
    logic             id_d;
    logic             disp_on_d;
    logic             cursor_on;
    logic             cursor_on_d;
    logic             blink;
    logic             blink_d;
    logic             cmd_err_d;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_cnt_d;
    clr_state_t       clr_state;
    clr_state_t       clr_state_d;
    logic [6:0]       clr_addr;
    logic [6:0]       clr_addr_d;
    logic [6:0]       clr_cnt;
    logic [6:0]       clr_cnt_d;
    logic             start_clear;
    logic             lcd_on_q;
    logic             cursor_hit;
    logic [6:0]       scan_addr;
    op_t              op;

    assign rise      = LCD_EN & ~en_q;
    assign fall      = ~LCD_EN & en_q;
    assign wr_strobe = fall & ~LCD_RW & reset;
    assign busy      = (busy_cnt != '0);
    assign op        = decode_op(LCD_DATA);
    assign scan_addr = (scan_row ? DDRAM_LINE1 : DDRAM_LINE0) | {3'b000, scan_col};
    assign scan_char = lcd_on_q ? ram_scan_q : SPACE;

`ifdef HD44780_CGRAM_EN
    logic [7:0] cgram [0:63];
    logic       cg_sel;
    logic       cg_sel_d;
    logic       cg_we;
    logic [7:0] cg_bus_q;
    logic [5:0] cg_next;

    // CGRAM addressing wraps within its own 64 locations.
    assign cg_next    = id ? (ac[5:0] + 6'd1) : (ac[5:0] - 6'd1);
    assign ac_adv     = cg_sel ? {1'b0, cg_next} : ac_step(ac, id);
    assign bus_rdata  = cg_sel ? cg_bus_q : ram_bus_q;
    assign cursor_hit = (scan_addr == ac) && cursor_on && disp_on && !cg_sel;

    always_ff @(posedge clk) begin
        if (cg_we) begin
            cgram[ac[5:0]] <= LCD_DATA;
        end
        cg_bus_q <= cgram[ac_d[5:0]];
        cg_data  <= cgram[cg_addr][4:0];
    end
`else
    assign ac_adv     = ac_step(ac, id);
    assign bus_rdata  = ram_bus_q;
    assign cursor_hit = (scan_addr == ac) && cursor_on && disp_on;
`endif

    // The first cycle of a read drives the live snapshot; afterwards the held copy.
    assign rd_snap  = LCD_RS ? bus_rdata : {busy, ac};
    assign LCD_DATA = (LCD_EN && LCD_RW && reset) ? (en_q ? rd_q : rd_snap) : 8'bz;

    always_comb begin
        ac_d        = ac;
        id_d        = id;
        disp_on_d   = disp_on;
        cursor_on_d = cursor_on;
        blink_d     = blink;
        cmd_err_d   = cmd_err;
        busy_cnt_d  = busy ? (busy_cnt - CNT_W'(1)) : '0;
        clr_state_d = clr_state;
        clr_addr_d  = clr_addr;
        clr_cnt_d   = clr_cnt;
        start_clear = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = ac;
        ram_wdata   = LCD_DATA;
`ifdef HD44780_CGRAM_EN
        cg_sel_d    = cg_sel;
        cg_we       = 1'b0;
`endif

        if (wr_strobe && busy) begin
            cmd_err_d = 1'b1;
        end else if (wr_strobe) begin
            busy_cnt_d = CNT_W'(BUSY_CYCLES);
            if (LCD_RS) begin
`ifdef HD44780_CGRAM_EN
                if (cg_sel) begin
                    cg_we = 1'b1;
                end else begin
                    ram_we = 1'b1;
                end
`else
                ram_we = 1'b1;
`endif
                ac_d = ac_adv;
            end else begin
                case (op)
                    OP_DDRAM: begin
                        ac_d = ddram_legal(LCD_DATA[6:0]) ? LCD_DATA[6:0] : DDRAM_LINE0;
`ifdef HD44780_CGRAM_EN
                        cg_sel_d = 1'b0;
`endif
                    end
                    OP_CGRAM: begin
`ifdef HD44780_CGRAM_EN
                        ac_d     = {1'b0, LCD_DATA[5:0]};
                        cg_sel_d = 1'b1;
`endif
                    end
                    OP_SHIFT: begin
                        if (!LCD_DATA[3]) begin
                            ac_d = ac_step(ac, LCD_DATA[2]);
                        end
                    end
                    OP_DISPLAY: begin
                        disp_on_d   = LCD_DATA[2];
                        cursor_on_d = LCD_DATA[1];
                        blink_d     = LCD_DATA[0];
                    end
                    OP_ENTRY: begin
                        id_d = LCD_DATA[1];
                    end
                    OP_HOME: begin
                        ac_d       = DDRAM_LINE0;
                        busy_cnt_d = CNT_W'(CLEAR_CYCLES);
`ifdef HD44780_CGRAM_EN
                        cg_sel_d   = 1'b0;
`endif
                    end
                    OP_CLEAR: begin
                        ac_d        = DDRAM_LINE0;
                        id_d        = 1'b1;
                        busy_cnt_d  = CNT_W'(CLEAR_CYCLES);
                        start_clear = 1'b1;
`ifdef HD44780_CGRAM_EN
                        cg_sel_d    = 1'b0;
`endif
                    end
                    OP_NOP: begin
                        busy_cnt_d = '0;
                    end
                    default: ;
                endcase
            end
        end else if (fall && LCD_RW && LCD_RS && reset) begin
            ac_d = ac_adv;
        end

        // The clear engine takes the RAM write port for its whole sweep.
        case (clr_state)
            CLR_RUN: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_addr;
                ram_wdata  = SPACE;
                clr_addr_d = ac_step(clr_addr, 1'b1);
                clr_cnt_d  = clr_cnt + 7'd1;
                if (clr_cnt == CLR_LAST) begin
                    clr_state_d = CLR_IDLE;
                end
            end
            default: begin
                if (start_clear) begin
                    clr_state_d = CLR_RUN;
                    clr_addr_d  = DDRAM_LINE0;
                    clr_cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q        <= 1'b0;
            rd_q        <= '0;
            ac          <= DDRAM_LINE0;
            id          <= 1'b1;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink       <= 1'b0;
            cmd_err     <= 1'b0;
            busy_cnt    <= CNT_W'(CLEAR_CYCLES);
            clr_state   <= CLR_RUN;
            clr_addr    <= DDRAM_LINE0;
            clr_cnt     <= '0;
            lcd_on_q    <= 1'b0;
            scan_cursor <= 1'b0;
`ifdef HD44780_CGRAM_EN
            cg_sel      <= 1'b0;
`endif
        end else begin
            en_q        <= LCD_EN;
            if (rise) begin
                rd_q <= rd_snap;
            end
            ac          <= ac_d;
            id          <= id_d;
            disp_on     <= disp_on_d;
            cursor_on   <= cursor_on_d;
            blink       <= blink_d;
            cmd_err     <= cmd_err_d;
            busy_cnt    <= busy_cnt_d;
            clr_state   <= clr_state_d;
            clr_addr    <= clr_addr_d;
            clr_cnt     <= clr_cnt_d;
            lcd_on_q    <= LCD_ON;
            scan_cursor <= cursor_hit;
`ifdef HD44780_CGRAM_EN
            cg_sel      <= cg_sel_d;
`endif
        end
    end

    hd44780_ddram u_ddram (
        .clk       (clk),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .bus_addr  (ac_d),
        .bus_q     (ram_bus_q),
        .scan_addr (scan_addr),
        .scan_q    (ram_scan_q)
    );

endmodule

// File: tb/tb_hd44780_panel_responder.sv
// Directed self-checking bench for hd44780_panel_responder acting as an LCD host.
module tb_hd44780_panel_responder;

    localparam int BUSY_CYC  = 50;
    localparam int CLEAR_CYC = 1600;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_on;
    logic       scan_row;
    logic [3:0] scan_col;
    logic       host_oe;
    logic [7:0] host_d;
    wire  [7:0] lcd_data;
    wire  [7:0] scan_char;
    wire        scan_cursor;
    wire        disp_on;
    wire        busy;
    wire        cmd_err;
`ifdef HD44780_CGRAM_EN
    logic [5:0] cg_addr;
    wire  [4:0] cg_data;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    assign lcd_data = host_oe ? host_d : 8'bz;

    hd44780_panel_responder #(
        .BUSY_CYCLES  (BUSY_CYC),
        .CLEAR_CYCLES (CLEAR_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .LCD_DATA    (lcd_data),
        .LCD_EN      (lcd_en),
        .LCD_RS      (lcd_rs),
        .LCD_RW      (lcd_rw),
        .LCD_ON      (lcd_on),
        .scan_row    (scan_row),
        .scan_col    (scan_col),
        .scan_char   (scan_char),
        .scan_cursor (scan_cursor),
        .disp_on     (disp_on),
        .busy        (busy),
        .cmd_err     (cmd_err)
`ifdef HD44780_CGRAM_EN
        ,
        .cg_addr     (cg_addr),
        .cg_data     (cg_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rw  = 1'b0;
        lcd_rs  = rs;
        host_d  = d;
        host_oe = 1'b1;
        lcd_en  = 1'b1;
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        repeat (2) @(negedge clk);
        host_oe = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d);
        @(negedge clk);
        host_oe = 1'b0;
        lcd_rs  = rs;
        lcd_rw  = 1'b1;
        lcd_en  = 1'b1;
        repeat (2) @(negedge clk);
        d = lcd_data;
        lcd_en = 1'b0;
        repeat (2) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, limit);
        end
    endtask

    task automatic scan_at(input logic r, input logic [3:0] c, output logic [7:0] ch, output logic cur);
        @(negedge clk);
        scan_row = r;
        scan_col = c;
        @(negedge clk);
        ch  = scan_char;
        cur = scan_cursor;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       cur;
        int         t0;
        int         dur;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared += 5;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 1", busy); end
        if (disp_on !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_disp_on: got %b expected 0", disp_on); end
        if (cmd_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_cmd_err: got %b expected 0", cmd_err); end
        if (scan_char !== 8'h20) begin mismatched++; $display("[TB] FAIL rst_scan_char: got %h expected 20", scan_char); end
        if (scan_cursor !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_scan_cursor: got %b expected 0", scan_cursor); end
        reset = 1'b1;
        t0 = cyc;
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h80) begin mismatched++; $display("[TB] FAIL rst_status_busy: got %h expected 80", d); end
        wait_ready("rst_clear_done", CLEAR_CYC + 100);
        dur = cyc - t0;
        compared++;
        if (dur < CLEAR_CYC - 2 || dur > CLEAR_CYC + 2) begin
            mismatched++;
            $display("[TB] FAIL rst_busy_len: got %0d expected %0d", dur, CLEAR_CYC);
        end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_status_idle: got %h expected 00", d); end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                scan_at(r[0], c[3:0], d, cur);
                compared++;
                if (d !== 8'h20) begin
                    mismatched++;
                    $display("[TB] FAIL rst_scan r%0d c%0d: got %h expected 20", r, c, d);
                end
            end
        end
    endtask

    task automatic test_write_hi;
        logic [7:0] d;
        logic       cur;
        bus_write(1'b0, 8'h0F); wait_ready("hi_0F", 200);
        compared++;
        if (disp_on !== 1'b1) begin mismatched++; $display("[TB] FAIL hi_disp_on: got %b expected 1", disp_on); end
        bus_write(1'b0, 8'h80); wait_ready("hi_80", 200);
        bus_write(1'b1, 8'h48); wait_ready("hi_H", 200);
        bus_write(1'b1, 8'h69); wait_ready("hi_i", 200);
        scan_at(1'b0, 4'd0, d, cur);
        compared++;
        if (d !== 8'h48) begin mismatched++; $display("[TB] FAIL hi_col0: got %h expected 48", d); end
        scan_at(1'b0, 4'd1, d, cur);
        compared += 2;
        if (d !== 8'h69) begin mismatched++; $display("[TB] FAIL hi_col1: got %h expected 69", d); end
        if (cur !== 1'b0) begin mismatched++; $display("[TB] FAIL hi_cursor_col1: got %b expected 0", cur); end
        scan_at(1'b0, 4'd2, d, cur);
        compared++;
        if (cur !== 1'b1) begin mismatched++; $display("[TB] FAIL hi_cursor_col2: got %b expected 1", cur); end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h02) begin mismatched++; $display("[TB] FAIL hi_status: got %h expected 02", d); end
    endtask

    task automatic test_line_wrap;
        logic [7:0] d;
        logic       cur;
        bus_write(1'b0, 8'hA7); wait_ready("wrap_A7", 200);
        bus_write(1'b1, 8'h58); wait_ready("wrap_X", 200);
        bus_write(1'b1, 8'h59); wait_ready("wrap_Y", 200);
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h41) begin mismatched++; $display("[TB] FAIL wrap_status: got %h expected 41", d); end
        scan_at(1'b1, 4'd0, d, cur);
        compared++;
        if (d !== 8'h59) begin mismatched++; $display("[TB] FAIL wrap_row1_col0: got %h expected 59", d); end
        bus_write(1'b0, 8'hA7); wait_ready("wrap_A7b", 200);
        bus_read(1'b1, d);
        compared++;
        if (d !== 8'h58) begin mismatched++; $display("[TB] FAIL wrap_read_27: got %h expected 58", d); end
        bus_read(1'b1, d);
        compared++;
        if (d !== 8'h59) begin mismatched++; $display("[TB] FAIL wrap_read_40: got %h expected 59", d); end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h41) begin mismatched++; $display("[TB] FAIL wrap_read_status: got %h expected 41", d); end
    endtask

    task automatic test_decrement_and_err;
        logic [7:0] d;
        logic       cur;
        bus_write(1'b0, 8'h04); wait_ready("dec_04", 200);
        bus_write(1'b0, 8'h80); wait_ready("dec_80", 200);
        compared++;
        if (cmd_err !== 1'b0) begin mismatched++; $display("[TB] FAIL err_before: got %b expected 0", cmd_err); end
        bus_write(1'b1, 8'h5A);
        bus_write(1'b1, 8'h51);
        compared++;
        if (cmd_err !== 1'b1) begin mismatched++; $display("[TB] FAIL err_sticky: got %b expected 1", cmd_err); end
        wait_ready("dec_Z", 200);
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h67) begin mismatched++; $display("[TB] FAIL dec_status: got %h expected 67", d); end
        scan_at(1'b0, 4'd0, d, cur);
        compared++;
        if (d !== 8'h5A) begin mismatched++; $display("[TB] FAIL dec_col0: got %h expected 5a", d); end
        bus_read(1'b1, d);
        compared++;
        if (d !== 8'h20) begin mismatched++; $display("[TB] FAIL err_ignored: got %h expected 20", d); end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h66) begin mismatched++; $display("[TB] FAIL dec_read_step: got %h expected 66", d); end
        bus_write(1'b0, 8'h06); wait_ready("dec_06", 200);
    endtask

    task automatic test_data_read;
        logic [7:0] d;
        logic       cur;
        bus_write(1'b0, 8'hC5); wait_ready("rd_C5", 200);
        bus_write(1'b1, 8'h4D); wait_ready("rd_M", 200);
        bus_write(1'b0, 8'hC5); wait_ready("rd_C5b", 200);
        bus_read(1'b1, d);
        compared++;
        if (d !== 8'h4D) begin mismatched++; $display("[TB] FAIL rd_data_45: got %h expected 4d", d); end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h46) begin mismatched++; $display("[TB] FAIL rd_status: got %h expected 46", d); end
        scan_at(1'b1, 4'd5, d, cur);
        compared++;
        if (d !== 8'h4D) begin mismatched++; $display("[TB] FAIL rd_scan_r1c5: got %h expected 4d", d); end
    endtask

    task automatic test_illegal_addr;
        logic [7:0] cmds [4];
        logic [7:0] d;
        cmds = '{8'hA8, 8'hBF, 8'hE8, 8'hFF};
        foreach (cmds[i]) begin
            bus_write(1'b0, 8'hC1); wait_ready("ill_pre", 200);
            bus_write(1'b0, cmds[i]); wait_ready("ill_set", 200);
            bus_read(1'b0, d);
            compared++;
            if (d !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL illegal_addr %h: got %h expected 00", cmds[i], d);
            end
        end
    endtask

    task automatic test_display_ctrl;
        logic [7:0] d;
        logic       cur;
        bus_write(1'b0, 8'h08); wait_ready("dc_08", 200);
        compared++;
        if (disp_on !== 1'b0) begin mismatched++; $display("[TB] FAIL dc_off: got %b expected 0", disp_on); end
        lcd_on = 1'b0;
        scan_at(1'b0, 4'd0, d, cur);
        compared++;
        if (d !== 8'h20) begin mismatched++; $display("[TB] FAIL dc_lcd_off: got %h expected 20", d); end
        lcd_on = 1'b1;
        bus_write(1'b0, 8'h0C); wait_ready("dc_0C", 200);
        scan_at(1'b0, 4'd0, d, cur);
        compared += 3;
        if (d !== 8'h5A) begin mismatched++; $display("[TB] FAIL dc_lcd_on: got %h expected 5a", d); end
        if (cur !== 1'b0) begin mismatched++; $display("[TB] FAIL dc_cursor_off: got %b expected 0", cur); end
        if (disp_on !== 1'b1) begin mismatched++; $display("[TB] FAIL dc_on: got %b expected 1", disp_on); end
        bus_write(1'b0, 8'h14); wait_ready("dc_shift", 200);
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h01) begin mismatched++; $display("[TB] FAIL dc_shift_right: got %h expected 01", d); end
    endtask

    task automatic test_home_clear;
        logic [7:0] d;
        logic       cur;
        bus_write(1'b0, 8'hC3); wait_ready("hc_C3", 200);
        bus_write(1'b0, 8'h02);
        repeat (100) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL home_long_busy: got %b expected 1", busy); end
        wait_ready("hc_home", CLEAR_CYC + 100);
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h00) begin mismatched++; $display("[TB] FAIL home_ac: got %h expected 00", d); end
        bus_write(1'b0, 8'h04); wait_ready("hc_04", 200);
        bus_write(1'b0, 8'h01); wait_ready("hc_clear", CLEAR_CYC + 100);
        scan_at(1'b0, 4'd0, d, cur);
        compared++;
        if (d !== 8'h20) begin mismatched++; $display("[TB] FAIL clear_r0c0: got %h expected 20", d); end
        scan_at(1'b1, 4'd5, d, cur);
        compared++;
        if (d !== 8'h20) begin mismatched++; $display("[TB] FAIL clear_r1c5: got %h expected 20", d); end
        bus_write(1'b1, 8'h41); wait_ready("hc_A", 200);
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h01) begin mismatched++; $display("[TB] FAIL clear_id_inc: got %h expected 01", d); end
    endtask

    task automatic test_reset_mid_clear;
        logic [7:0] d;
        int         t0;
        int         dur;
        bus_write(1'b0, 8'h01);
        repeat (500) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        t0 = cyc;
        compared++;
        if (cmd_err !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_cmd_err: got %b expected 0", cmd_err); end
        wait_ready("mid_clear", CLEAR_CYC + 100);
        dur = cyc - t0;
        compared++;
        if (dur < CLEAR_CYC - 2 || dur > CLEAR_CYC + 2) begin
            mismatched++;
            $display("[TB] FAIL mid_busy_len: got %0d expected %0d", dur, CLEAR_CYC);
        end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_status: got %h expected 00", d); end
    endtask

`ifdef HD44780_CGRAM_EN
    task automatic test_cgram;
        logic [7:0] d;
        bus_write(1'b0, 8'h48); wait_ready("cg_48", 200);
        bus_write(1'b1, 8'h1F); wait_ready("cg_1F", 200);
        @(negedge clk);
        cg_addr = 6'd8;
        @(negedge clk);
        compared++;
        if (cg_data !== 5'h1F) begin mismatched++; $display("[TB] FAIL cg_glyph: got %h expected 1f", cg_data); end
        bus_read(1'b0, d);
        compared++;
        if (d !== 8'h09) begin mismatched++; $display("[TB] FAIL cg_status: got %h expected 09", d); end
        bus_write(1'b0, 8'h80); wait_ready("cg_80", 200);
    endtask
`endif

    initial begin
        reset    = 1'b1;
        lcd_en   = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_on   = 1'b1;
        scan_row = 1'b0;
        scan_col = 4'd0;
        host_oe  = 1'b0;
        host_d   = 8'h00;
`ifdef HD44780_CGRAM_EN
        cg_addr  = 6'd0;
`endif
        test_reset();
        test_write_hi();
        test_line_wrap();
        test_decrement_and_err();
        test_data_read();
        test_illegal_addr();
        test_display_ctrl();
        test_home_clear();
        test_reset_mid_clear();
`ifdef HD44780_CGRAM_EN
        test_cgram();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
